// File: rtl/decade_count_checker.sv
// Receive-side monitor for a 4-bit decade counter: locks onto the 0..9 wrap
// sequence, flags violations, illegal codes and restarts, and keeps statistics.
module decade_count_checker #(
  parameter int LOCK_CNT = 3,
  parameter int ERRW     = 8,
  parameter int WRAPW    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic [3:0]       q,
  output logic             locked,
  output logic             err_pulse,
  output logic             bad_code,
  output logic             restart_pulse,
  output logic             wrap_pulse,
  output logic [ERRW-1:0]  err_count,
  output logic [WRAPW-1:0] wrap_count
);

  // state   | meaning
  // UNSYNC  | no reference value yet, waiting for a legal code
  // ACQUIRE | counting consecutive correct increments toward lock
  // LOCKED  | sequence tracked, violations reported as errors
  localparam logic [1:0] UNSYNC  = 2'd0;
  localparam logic [1:0] ACQUIRE = 2'd1;
  localparam logic [1:0] LOCKED  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [3:0]       prev_q, prev_d;
  logic [3:0]       match_q, match_d;
  logic             err_q, err_d;
  logic             bad_q, bad_d;
  logic             restart_q, restart_d;
  logic             wrap_q, wrap_d;
  logic [ERRW-1:0]  err_count_q, err_count_d;
  logic [WRAPW-1:0] wrap_count_q, wrap_count_d;

  logic       q_legal;
  logic [3:0] exp_val;
  logic [3:0] match_inc;

  assign q_legal   = (q <= 4'd9);
  assign exp_val   = (prev_q == 4'd9) ? 4'd0 : prev_q + 4'd1;
  assign match_inc = match_q + 4'd1;

  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    match_d      = match_q;
    err_d        = 1'b0;
    bad_d        = 1'b0;
    restart_d    = 1'b0;
    wrap_d       = 1'b0;
    err_count_d  = err_count_q;
    wrap_count_d = wrap_count_q;

    if (sample_en) begin
      if (q_legal) prev_d = q;
      case (state_q)
        UNSYNC: begin
          if (q_legal) begin
            state_d = ACQUIRE;
            match_d = 4'd0;
          end else begin
            bad_d = 1'b1;
          end
        end
        ACQUIRE: begin
          if (!q_legal) begin
            bad_d   = 1'b1;
            state_d = UNSYNC;
          end else if (q == exp_val) begin
            match_d = match_inc;
            if (match_inc == LOCK_CNT[3:0]) state_d = LOCKED;
          end else begin
            match_d = 4'd0;
          end
        end
        LOCKED: begin
          if (!q_legal) begin
            bad_d   = 1'b1;
            err_d   = 1'b1;
            state_d = UNSYNC;
          end else if (q == exp_val) begin
            if (prev_q == 4'd9) begin
              wrap_d       = 1'b1;
              wrap_count_d = wrap_count_q + WRAPW'(1);
            end
          end else if (q == 4'd0) begin
            // Early return to zero means the upstream counter was reset.
            restart_d = 1'b1;
            state_d   = ACQUIRE;
            match_d   = 4'd0;
            prev_d    = 4'd0;
          end else begin
            err_d   = 1'b1;
            state_d = ACQUIRE;
            match_d = 4'd0;
          end
        end
        default: state_d = UNSYNC;
      endcase
    end

    if (err_d && (err_count_q != {ERRW{1'b1}})) err_count_d = err_count_q + ERRW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= UNSYNC;
      prev_q       <= 4'd0;
      match_q      <= 4'd0;
      err_q        <= 1'b0;
      bad_q        <= 1'b0;
      restart_q    <= 1'b0;
      wrap_q       <= 1'b0;
      err_count_q  <= '0;
      wrap_count_q <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      match_q      <= match_d;
      err_q        <= err_d;
      bad_q        <= bad_d;
      restart_q    <= restart_d;
      wrap_q       <= wrap_d;
      err_count_q  <= err_count_d;
      wrap_count_q <= wrap_count_d;
    end
  end

  assign locked        = (state_q == LOCKED);
  assign err_pulse     = err_q;
  assign bad_code      = bad_q;
  assign restart_pulse = restart_q;
  assign wrap_pulse    = wrap_q;
  assign err_count     = err_count_q;
  assign wrap_count    = wrap_count_q;

endmodule

// File: tb/tb_decade_count_checker.sv
// Directed vector bench for decade_count_checker; a second instance with a
// 2-bit error counter sees the same stimulus to exercise saturation.
module tb_decade_count_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       sample_en;
  logic [3:0] q;

  logic       locked, err_pulse, bad_code, restart_pulse, wrap_pulse;
  logic [7:0] err_count, wrap_count;
  logic       locked2, err_pulse2, bad_code2, restart_pulse2, wrap_pulse2;
  logic [1:0] err_count2;
  logic [7:0] wrap_count2;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  decade_count_checker #(.LOCK_CNT(3), .ERRW(8), .WRAPW(8)) u_dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .q(q),
    .locked(locked), .err_pulse(err_pulse), .bad_code(bad_code),
    .restart_pulse(restart_pulse), .wrap_pulse(wrap_pulse),
    .err_count(err_count), .wrap_count(wrap_count)
  );

  decade_count_checker #(.LOCK_CNT(3), .ERRW(2), .WRAPW(8)) u_dut_sat (
    .clk(clk), .reset(reset), .sample_en(sample_en), .q(q),
    .locked(locked2), .err_pulse(err_pulse2), .bad_code(bad_code2),
    .restart_pulse(restart_pulse2), .wrap_pulse(wrap_pulse2),
    .err_count(err_count2), .wrap_count(wrap_count2)
  );

  typedef struct {
    logic       en;
    logic [3:0] q;
    logic       lk;
    logic       ep;
    logic       bc;
    logic       rp;
    logic       wp;
    logic [7:0] ec;
    logic [7:0] wc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic en, logic [3:0] qv, logic lk, logic ep, logic bc,
                              logic rp, logic wp, int ec, int wc);
    vec_t v;
    v.en = en; v.q = qv; v.lk = lk; v.ep = ep; v.bc = bc;
    v.rp = rp; v.wp = wp; v.ec = 8'(ec); v.wc = 8'(wc);
    return v;
  endfunction

  task automatic cmp(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input vec_t v);
    logic [7:0] ec_sat;
    ec_sat = (v.ec > 8'd3) ? 8'd3 : v.ec;
    n_vec++;
    cmp("locked",        idx, {7'd0, locked},        {7'd0, v.lk});
    cmp("err_pulse",     idx, {7'd0, err_pulse},     {7'd0, v.ep});
    cmp("bad_code",      idx, {7'd0, bad_code},      {7'd0, v.bc});
    cmp("restart_pulse", idx, {7'd0, restart_pulse}, {7'd0, v.rp});
    cmp("wrap_pulse",    idx, {7'd0, wrap_pulse},    {7'd0, v.wp});
    cmp("err_count",     idx, err_count,             v.ec);
    cmp("wrap_count",    idx, wrap_count,            v.wc);
    cmp("sat_locked",    idx, {7'd0, locked2},       {7'd0, v.lk});
    cmp("sat_err_count", idx, {6'd0, err_count2},    ec_sat);
  endtask

  initial begin
    //                en  q  lk ep bc rp wp ec wc
    vecs.push_back(mk(1,  0, 0, 0, 0, 0, 0, 0, 0)); // UNSYNC -> ACQUIRE
    vecs.push_back(mk(1,  1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0,  7, 0, 0, 0, 0, 0, 0, 0)); // gap ignored
    vecs.push_back(mk(1,  2, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1,  3, 1, 0, 0, 0, 0, 0, 0)); // lock
    vecs.push_back(mk(1,  4, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1,  5, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0,  0, 1, 0, 0, 0, 0, 0, 0)); // gap while locked
    vecs.push_back(mk(1,  6, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1,  7, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1,  8, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1,  9, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1,  0, 1, 0, 0, 0, 1, 0, 1)); // wrap
    vecs.push_back(mk(1,  1, 1, 0, 0, 0, 0, 0, 1)); // pulse drops
    vecs.push_back(mk(1,  2, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1,  3, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1,  4, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1,  5, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1,  0, 0, 0, 0, 1, 0, 0, 1)); // restart
    vecs.push_back(mk(1,  1, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1,  2, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1,  3, 1, 0, 0, 0, 0, 0, 1)); // relock
    vecs.push_back(mk(1,  4, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1,  6, 0, 1, 0, 0, 0, 1, 1)); // skip
    vecs.push_back(mk(1,  7, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1,  8, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1,  9, 1, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1,  0, 1, 0, 0, 0, 1, 1, 2));
    vecs.push_back(mk(1, 12, 0, 1, 1, 0, 0, 2, 2)); // illegal while locked
    vecs.push_back(mk(1, 13, 0, 0, 1, 0, 0, 2, 2)); // illegal in UNSYNC
    vecs.push_back(mk(1,  8, 0, 0, 0, 0, 0, 2, 2));
    vecs.push_back(mk(1,  9, 0, 0, 0, 0, 0, 2, 2));
    vecs.push_back(mk(1,  0, 0, 0, 0, 0, 0, 2, 2)); // wrap before lock not counted
    vecs.push_back(mk(1,  1, 1, 0, 0, 0, 0, 2, 2));
    vecs.push_back(mk(1,  1, 0, 1, 0, 0, 0, 3, 2)); // hold is an error
    vecs.push_back(mk(1, 11, 0, 0, 1, 0, 0, 3, 2)); // illegal in ACQUIRE
    vecs.push_back(mk(1,  2, 0, 0, 0, 0, 0, 3, 2));
    vecs.push_back(mk(1,  3, 0, 0, 0, 0, 0, 3, 2));
    vecs.push_back(mk(1,  4, 0, 0, 0, 0, 0, 3, 2));
    vecs.push_back(mk(1,  5, 1, 0, 0, 0, 0, 3, 2));
    vecs.push_back(mk(1,  3, 0, 1, 0, 0, 0, 4, 2)); // backward step
    vecs.push_back(mk(1,  4, 0, 0, 0, 0, 0, 4, 2));
    vecs.push_back(mk(1,  5, 0, 0, 0, 0, 0, 4, 2));
    vecs.push_back(mk(1,  6, 1, 0, 0, 0, 0, 4, 2));
    vecs.push_back(mk(1,  9, 0, 1, 0, 0, 0, 5, 2)); // skip, fifth error
    vecs.push_back(mk(1,  2, 0, 0, 0, 0, 0, 5, 2)); // re-seed, no error
    vecs.push_back(mk(1,  3, 0, 0, 0, 0, 0, 5, 2));
    vecs.push_back(mk(1,  4, 0, 0, 0, 0, 0, 5, 2));
    vecs.push_back(mk(1,  5, 1, 0, 0, 0, 0, 5, 2));
    vecs.push_back(mk(1,  6, 1, 0, 0, 0, 0, 5, 2));

    reset = 1'b1;
    sample_en = 1'b0;
    q = 4'd0;
    repeat (2) @(negedge clk);
    check_all(-1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      sample_en = vecs[i].en;
      q = vecs[i].q;
      @(posedge clk);
      @(negedge clk);
      check_all(i, vecs[i]);
    end

    // Async reset mid-cycle while locked with nonzero counters.
    sample_en = 1'b1;
    q = 4'd7;
    #2;
    reset = 1'b1;
    #1;
    check_all(100, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b0;

    // After reset, prev is 0: sample 1 starts acquisition from 1 with no errors.
    q = 4'd1;
    @(posedge clk);
    @(negedge clk);
    check_all(101, mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 2; k <= 4; k++) begin
      q = 4'(k);
      @(posedge clk);
      @(negedge clk);
      check_all(100 + k, mk(1, 4'(k), (k == 4), 0, 0, 0, 0, 0, 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/decade_count_checker.md
Name: decade_count_checker

Overview:
- Receive-side monitor for a 4-bit decade counter output: samples the count stream, locks onto the 0..9 wrap sequence, flags sequence violations, illegal codes and restarts, and keeps statistics.
- Sits beside any decade counter instance, or at the far end of a registered count bus.
- Used in-system as a health monitor and reused by benches as a self-checking sink.

Parameters:
- LOCK_CNT, 3, number of consecutive correct increments needed in ACQUIRE before entering LOCKED (legal range 1..15).
- ERRW, 8, width of the saturating error counter.
- WRAPW, 8, width of the wrap counter; wraps modulo 2^WRAPW.

Ports:
- clk  in  1  system clock; rising edge.
- reset  in  1  asynchronous, active-high reset.
- sample_en  in  1  q is valid this cycle; the checker ignores q when low.
- q  in  4  observed counter value.
- locked  out  1  high while the FSM is in LOCKED.
- err_pulse  out  1  one-cycle pulse on a sequence violation or illegal code while LOCKED.
- bad_code  out  1  one-cycle pulse when a sampled q is greater than 9, in any state.
- restart_pulse  out  1  one-cycle pulse when q returns to 0 early while LOCKED (counter was reset).
- wrap_pulse  out  1  one-cycle pulse on a sampled 9 to 0 transition while LOCKED.
- err_count  out  ERRW  saturating count of err_pulse events.
- wrap_count  out  WRAPW  count of wrap_pulse events.

Behaviour:
Reset:
- reset is asynchronous and active-high. While high, all outputs are 0 and the FSM is in UNSYNC.
- Internal prev register resets to 0; match counter resets to 0.
- On the first rising clk edge after reset falls, the block operates normally.

Sampling and timing:
- Only cycles with sample_en=1 are evaluated; all state holds when sample_en=0.
- exp = (prev==9) ? 0 : prev+1.
- On every sampled cycle with q<=9: prev <= q.
- A sample with q>9 never updates prev.
- All outputs are registered: a sample at edge N produces its response visible after edge N, i.e. 1-cycle latency.
- Pulses last exactly 1 cycle, even when sample_en stays high.

State machine:
- UNSYNC:
  - q<=9: load prev, match counter <= 0, go to ACQUIRE.
  - q>9: bad_code=1, stay in UNSYNC.
- ACQUIRE:
  - q==exp: match counter +1. When the counter reaches LOCK_CNT, go to LOCKED and set locked=1 in the same output cycle.
  - q!=exp with q<=9: match counter <= 0, stay in ACQUIRE with prev <= q. This is a re-seed; no err_pulse is raised.
  - q>9: bad_code=1, go to UNSYNC.
- LOCKED, evaluated in priority order:
  1. q>9: bad_code=1 and err_pulse=1, go to UNSYNC, locked=0.
  2. q==exp: stay in LOCKED. If prev==9 and q==0, wrap_pulse=1 and wrap_count+1.
  3. q==0 and exp!=0: restart_pulse=1, no error. Go to ACQUIRE with match counter 0 and prev 0; locked=0.
  4. Otherwise (skip, hold or backward step): err_pulse=1, go to ACQUIRE, re-seed prev <= q, locked=0.

Arithmetic and boundaries:
- err_count saturates at all-ones and never wraps.
- wrap_count wraps modulo 2^WRAPW.
- A held value (q==prev) while LOCKED counts as an error; the upstream counter must advance on every sample.
- Asserting reset mid-stream clears the statistics and returns to UNSYNC immediately, without waiting for a clock edge.
- bad_code and err_pulse may assert in the same cycle only under LOCKED rule 1.

Test Plan:
- Reset, then sample_en=1 with q = 0,1,2,3 on consecutive cycles -> locked rises 1 cycle after q=3 is sampled (LOCK_CNT=3); err_count stays 0.
- Locked, drive 4..9, 0, 1 -> exactly one wrap_pulse, 1 cycle after q=0 is sampled; wrap_count=1; locked stays 1.
- Locked at q=5, next sample q=0 (mimics counter reset) -> restart_pulse=1, locked=0, err_count unchanged. Then 1,2,3 -> locked=1 again.
- Locked at q=4, next sample q=6 -> err_pulse=1, err_count=1, locked=0. Then 7,8,9 -> relocks; wrap at 9 to 0 is not counted until locked.
- q=12 sampled while locked -> bad_code=1, err_pulse=1, FSM goes to UNSYNC. With ERRW=2, forcing 5 errors -> err_count holds at 3.
- Assert reset asynchronously mid-cycle while locked with nonzero counters -> all outputs read 0 before the next clk edge. sample_en=0 gaps inside a valid sequence -> no effect on lock or counters.
